// File: rtl/morse_tx_serial.sv
// morse_tx_serial: FIFO-queued Morse transmitter for digits 0-9 with unit-timed keying.
// Build option MORSE_WORD_GAP_EN stretches the silence after the last queued character to 7 units.
module morse_tx_serial #(
  parameter int UNIT_CYCLES    = 4,
  parameter int DASH_UNITS     = 3,
  parameter int CHAR_GAP_UNITS = 3,
  parameter int DEPTH          = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] num,
  input  logic       num_valid,
  output logic       num_ready,
  output logic       key,
  output logic       ponto,
  output logic       traco,
  output logic       busy,
  output logic       err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = $clog2(DASH_UNITS * UNIT_CYCLES) + 1;

  localparam logic [CNT_W-1:0] DOT_LEN  = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DASH_LEN = CNT_W'(DASH_UNITS * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CGAP_LEN = CNT_W'(CHAR_GAP_UNITS * UNIT_CYCLES - 1);
`ifdef MORSE_WORD_GAP_EN
  localparam logic [CNT_W-1:0] WGAP_LEN = CNT_W'((7 - CHAR_GAP_UNITS) * UNIT_CYCLES - 1);
`endif
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MARK  = 3'd1,
    S_SPACE = 3'd2,
    S_CGAP  = 3'd3
`ifdef MORSE_WORD_GAP_EN
    , S_WGAP = 3'd4
`endif
  } state_t;

  // 5-element code, MSB sent first, 1 = dot and 0 = dash.
  function automatic logic [4:0] code_of(input logic [3:0] d);
    logic [4:0] c;
    c = 5'b00000;
    case (d)
      4'd0:    c = 5'b00000;
      4'd1:    c = 5'b10000;
      4'd2:    c = 5'b11000;
      4'd3:    c = 5'b11100;
      4'd4:    c = 5'b11110;
      4'd5:    c = 5'b11111;
      4'd6:    c = 5'b01111;
      4'd7:    c = 5'b00111;
      4'd8:    c = 5'b00011;
      4'd9:    c = 5'b00001;
      default: c = 5'b00000;
    endcase
    return c;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [4:0]         sh_q, sh_d;
  logic [2:0]         idx_q, idx_d;

  logic [3:0]         mem_q [DEPTH];
  logic [3:0]         mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;

  logic key_q, key_d;
  logic ponto_q, ponto_d;
  logic traco_q, traco_d;
  logic busy_q, busy_d;
  logic err_q, err_d;

  logic push;
  logic pop;
  logic fifo_empty;

  // Handshake: a digit transfers on any rising edge with num_valid & num_ready;
  // num_ready depends only on the FIFO level, never on num_valid or a same-cycle pop.
  assign fifo_empty = (level_q == '0);
  assign num_ready  = (level_q != FULL_LVL);

  always_comb begin
    push     = num_valid && num_ready && (num <= 4'd9);
    err_d    = num_valid && num_ready && (num > 4'd9);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      mem_d[wr_ptr_q] = num;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    idx_d   = idx_q;
    pop     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          sh_d    = code_of(mem_q[rd_ptr_q]);
          idx_d   = 3'd0;
          state_d = S_MARK;
        end
      end
      S_MARK: begin
        if (cnt_q == '0) begin
          state_d = (idx_q == 3'd4) ? S_CGAP : S_SPACE;
        end
      end
      S_SPACE: begin
        if (cnt_q == '0) begin
          sh_d    = {sh_q[3:0], 1'b0};
          idx_d   = idx_q + 3'd1;
          state_d = S_MARK;
        end
      end
      S_CGAP: begin
        // Popping on the last gap cycle keeps queued characters exactly one gap apart.
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            sh_d    = code_of(mem_q[rd_ptr_q]);
            idx_d   = 3'd0;
            state_d = S_MARK;
          end else begin
`ifdef MORSE_WORD_GAP_EN
            state_d = S_WGAP;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
`ifdef MORSE_WORD_GAP_EN
      S_WGAP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase

    // Counter reloads on every state entry, otherwise counts down to zero.
    if (state_d != state_q) begin
      unique case (state_d)
        S_MARK:  cnt_d = sh_d[4] ? DOT_LEN : DASH_LEN;
        S_SPACE: cnt_d = DOT_LEN;
        S_CGAP:  cnt_d = CGAP_LEN;
`ifdef MORSE_WORD_GAP_EN
        S_WGAP:  cnt_d = WGAP_LEN;
`endif
        default: cnt_d = '0;
      endcase
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end

    key_d   = (state_q == S_MARK);
    ponto_d = (state_q == S_MARK) && sh_q[4];
    traco_d = (state_q == S_MARK) && !sh_q[4];
    busy_d  = (state_q != S_IDLE) || !fifo_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sh_q     <= '0;
      idx_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      key_q    <= 1'b0;
      ponto_q  <= 1'b0;
      traco_q  <= 1'b0;
      busy_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      key_q    <= key_d;
      ponto_q  <= ponto_d;
      traco_q  <= traco_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

  assign key   = key_q;
  assign ponto = ponto_q;
  assign traco = traco_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule

// File: tb/tb_morse_tx_serial.sv
// tb_morse_tx_serial: random and directed digit traffic checked cycle by cycle against
// a timeline model built from the Morse timing rules.
module tb_morse_tx_serial;

  localparam int U     = 4;
  localparam int DU    = 3;
  localparam int CG    = 3;
  localparam int DEPTH = 4;
`ifdef MORSE_WORD_GAP_EN
  localparam int SIL = 7;
`else
  localparam int SIL = CG;
`endif
  localparam int NCYC = 8000;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] num = 4'd0;
  logic       num_valid = 1'b0;
  logic       num_ready, key, ponto, traco, busy, err;

  morse_tx_serial #(
    .UNIT_CYCLES(U),
    .DASH_UNITS(DU),
    .CHAR_GAP_UNITS(CG),
    .DEPTH(DEPTH)
  ) dut (
    .clock(clock),
    .reset(reset),
    .num(num),
    .num_valid(num_valid),
    .num_ready(num_ready),
    .key(key),
    .ponto(ponto),
    .traco(traco),
    .busy(busy),
    .err(err)
  );

  always #5 clock = ~clock;

  // Expected waveforms indexed by edge number; value holds just after that edge.
  bit exp_key   [NCYC];
  bit exp_ponto [NCYC];
  bit exp_traco [NCYC];
  bit exp_busy  [NCYC];
  bit exp_err   [NCYC];

  logic [3:0] exp_q[$];
  int         pop_t_q[$];
  int         prev_f = -1000;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_reset(input int t);
    for (int i = t; i < NCYC; i++) begin
      exp_key[i] = 1'b0; exp_ponto[i] = 1'b0; exp_traco[i] = 1'b0;
      exp_busy[i] = 1'b0; exp_err[i] = 1'b0;
    end
    exp_q.delete();
    pop_t_q.delete();
    prev_f = -1000;
  endtask

  // Digit d accepted at edge a: place its marks on the timeline.
  task automatic model_accept(input int d, input int a);
    int  s, t, len;
    bit  dot;
    exp_q.push_back(4'(d));
    if (a + 2 <= prev_f + CG * U) s = prev_f + CG * U;
    else s = (a + 2 > prev_f + SIL * U + 1) ? a + 2 : prev_f + SIL * U + 1;
    pop_t_q.push_back(s - 1);
    t = s;
    for (int k = 0; k < 5; k++) begin
      dot = (d <= 5) ? (k < d) : (k >= d - 5);
      len = dot ? U : DU * U;
      for (int i = t; i < t + len; i++) begin
        if (i < NCYC) begin
          exp_key[i] = 1'b1; exp_ponto[i] = dot; exp_traco[i] = !dot;
        end
      end
      t += len;
      if (k < 4) t += U;
    end
    prev_f = t;
    for (int i = a + 1; i < t + SIL * U; i++) begin
      if (i < NCYC) exp_busy[i] = 1'b1;
    end
  endtask

  // One clock: check outputs after edge cyc, drive inputs for edge cyc+1, advance model.
  task automatic step(input logic v, input logic [3:0] n, input logic r);
    @(negedge clock);
    check("key", key, exp_key[cyc]);
    check("ponto", ponto, exp_ponto[cyc]);
    check("traco", traco, exp_traco[cyc]);
    check("busy", busy, exp_busy[cyc]);
    check("err", err, exp_err[cyc]);
    check("num_ready", num_ready, exp_q.size() < DEPTH);
    num_valid = v;
    num       = n;
    reset     = r;
    if (r) begin
      model_reset(cyc + 1);
    end else begin
      if (v && exp_q.size() < DEPTH) begin
        if (n <= 4'd9) model_accept(int'(n), cyc + 1);
        else exp_err[cyc + 1] = 1'b1;
      end
      while (pop_t_q.size() > 0 && pop_t_q[0] == cyc + 1) begin
        void'(pop_t_q.pop_front());
        void'(exp_q.pop_front());
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clock);
    step(1'b0, 4'd0, 1'b1);
    step(1'b0, 4'd0, 1'b0);

    step(1'b1, 4'd5, 1'b0);
    idle(70);
    step(1'b1, 4'd0, 1'b0);
    idle(110);
    step(1'b1, 4'd1, 1'b0);
    step(1'b1, 4'd2, 1'b0);
    idle(170);
    for (int i = 0; i < 7; i++) step(1'b1, 4'($urandom_range(0, 9)), 1'b0);
    idle(460);
    step(1'b1, 4'd12, 1'b0);
    idle(10);
    step(1'b1, 4'd7, 1'b0);
    step(1'b1, 4'd8, 1'b0);
    step(1'b1, 4'd9, 1'b0);
    idle(6);
    step(1'b0, 4'd0, 1'b1);
    idle(120);
    step(1'b1, 4'd3, 1'b0);
    idle(100);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        step(1'b0, 4'd0, 1'b1);
      end else if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 4) == 0) step(1'b1, 4'($urandom_range(10, 15)), 1'b0);
        else step(1'b1, 4'($urandom_range(0, 9)), 1'b0);
      end else begin
        step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
      end
    end
    idle(500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/morse_tx_serial.md
Name: morse_tx_serial

Overview:
- Timed serial Morse transmitter for decimal digits 0-9.
- Accepts digits through a valid/ready handshake and queues them in a parametrised FIFO.
- Looks up the 5-element Morse code for each digit and plays it out on a keying line at a programmable unit rate, with dot/dash element strobes for the display segments.
- Sits between the digit-entry logic and the LED/buzzer driver; successor to the combinational digit-to-Morse encoder.

Parameters:
- UNIT_CYCLES, 4: clock cycles per Morse time unit; must be >= 1.
- DASH_UNITS, 3: dash mark length in units; must be >= 2.
- CHAR_GAP_UNITS, 3: key-off length in units between characters; must be >= 1.
- DEPTH, 4: FIFO depth in digits; power of two, >= 2.

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- num  in  4  digit to send, valid values 0-9
- num_valid  in  1  num is presented this cycle
- num_ready  out  1  FIFO not full; combinational from FIFO level
- key  out  1  registered; 1 while a mark (dot or dash) is sounding
- ponto  out  1  registered; 1 during dot marks only
- traco  out  1  registered; 1 during dash marks only
- busy  out  1  1 when the FSM is not IDLE or the FIFO is non-empty
- err  out  1  registered one-cycle pulse on rejected digit

Behaviour:
- Reset (synchronous, active-high), applied at any time including mid-character:
  - Next edge: FIFO emptied, FSM to IDLE, counters cleared.
  - key, ponto, traco and err all 0; busy 0; num_ready 1.
  - The in-progress character is abandoned.
- Handshake:
  - A digit is accepted on an edge where num_valid & num_ready.
  - num 0-9 is pushed into the FIFO.
  - num 10-15 is not stored; err pulses high the following cycle.
  - When full, num_ready is 0 and a push is blocked even if a pop occurs in the same cycle.
- Code table: 5 elements, sent MSB first; 1 = dot, 0 = dash.
  - 0 = 00000, 1 = 10000, 2 = 11000, 3 = 11100, 4 = 11110
  - 5 = 11111, 6 = 01111, 7 = 00111, 8 = 00011, 9 = 00001
- FSM states: IDLE, MARK, SPACE, CGAP (plus WGAP with the macro).
- IDLE:
  - If the FIFO is non-empty, pop, load the 5-bit code into a shift register, element index = 0, go to MARK.
  - key rises on the edge after the pop; with an idle block, key rises 2 edges after the accepting edge.
- MARK:
  - key = 1; ponto = current bit; traco = ~current bit.
  - Lasts UNIT_CYCLES cycles for a dot, DASH_UNITS*UNIT_CYCLES cycles for a dash.
  - Then SPACE if index < 4, else CGAP.
- SPACE:
  - key, ponto and traco all 0 for UNIT_CYCLES cycles.
  - Then advance index and shift, go to MARK.
- CGAP:
  - All marks 0 for CHAR_GAP_UNITS*UNIT_CYCLES cycles.
  - On the last cycle, if the FIFO is non-empty, pop and go straight to MARK, so back-to-back characters have exactly the char gap between them.
  - Otherwise go to IDLE (or WGAP with the macro).
- Timing counter: down-counter of width ceil(log2(DASH_UNITS*UNIT_CYCLES)) + 1, reloaded on every state entry.
- FIFO pointers wrap modulo DEPTH; level counter is log2(DEPTH)+1 bits wide.
- Push and pop in the same cycle on a non-full FIFO leaves the level unchanged.
- ponto and traco are never 1 simultaneously; each is 1 only while key = 1.

Optional Feature:
- Macro: MORSE_WORD_GAP_EN.
- Defined:
  - When CGAP ends with the FIFO empty, the FSM enters WGAP and holds key = 0 for a further (7 - CHAR_GAP_UNITS)*UNIT_CYCLES cycles, so total silence is 7 units.
  - Then it returns to IDLE.
  - WGAP always runs to completion; digits pushed during WGAP wait in the FIFO.
  - busy stays 1 during WGAP.
- Undefined: WGAP state absent; CGAP goes directly to IDLE.

Test Plan (defaults UNIT_CYCLES=4, DASH_UNITS=3, CHAR_GAP_UNITS=3, DEPTH=4, macro undefined unless noted):
1. Push 5 when idle -> key high 4 / low 4 cycles five times, with ponto mirroring key and traco always 0. The last mark is followed by 12 cycles low, then busy = 0. Total 48 cycles from the first key edge to busy falling.
2. Push 0 -> five marks of 12 cycles each, with traco = 1 during each mark and ponto = 0. Marks are separated by 4-cycle spaces.
3. Push 1 then 2 on consecutive cycles -> key pattern 4 on, then 4x(4 off, 12 on), then 12 off, then 4 on, 4 off, 4 on, then 3x(4 off, 12 on). The gap between characters is exactly 12 cycles.
4. Hold num_valid for 7 digits from idle -> 5 accepted (1 popped, 4 queued) and num_ready = 0. num_ready returns to 1 on the pop at the end of the first character's CGAP.
5. Push num = 12 -> err = 1 for exactly one cycle; key stays 0, busy stays 0, FIFO level unchanged.
6. Assert reset during a dash of digit 7 with 2 digits queued -> next cycle key = traco = 0, busy = 0, num_ready = 1, and no further marks appear. Repeat with MORSE_WORD_GAP_EN: push 3 -> key stays low 28 cycles after the last mark before busy falls.
